fp16_div_seq: RTL and testbench

Sequential IEEE 754 half-precision divider; the inverse companion to the team's combinational FP16 multiplier. It accepts operand pairs over a valid/ready handshake, normalizes subnormal inputs, and runs a radix-2 restoring mantissa division one quotient bit per cycle. It then rounds to nearest-even and presents the quotient with exception flags. It sits in the FP datapath beside the multiplier, and one division is in flight at a time.

---
 rtl/fp16_div_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_fp16_div_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp16_div_seq.sv
// Purpose : sequential IEEE 754 half-precision divider (restoring radix-2, RNE, subnormal flush on output).
// Latency : 15 cycles for normal operands, +1 per leading-zero NORM shift (max 25); special cases 1 cycle.
// Backpres: one division in flight; in_ready only in IDLE; result held with out_valid until out_ready.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready, na, nb   operand handshake: na = dividend, nb = divisor (FP16)
//   out_valid/out_ready     result handshake
//   quotient                FP16 result
//   flags                   {invalid, div_by_zero, overflow, underflow}
module fp16_div_seq #(
    parameter int BIAS  = 15,
    parameter int QBITS = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] na,
    input  logic [15:0] nb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [3:0]  flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic signed [6:0] BIAS_S = 7'(BIAS);
    localparam logic [3:0]        LAST_Q = 4'(QBITS - 1);

    state_t              state_q, state_d;
    logic [10:0]         ma_q, ma_d, mb_q, mb_d;
    logic signed [6:0]   ea_q, ea_d, eb_q, eb_d;
    logic [11:0]         rem_q, rem_d;
    logic [QBITS-1:0]    q_q, q_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                spec_q, spec_d;
    logic [15:0]         spec_res_q, spec_res_d;
    logic [3:0]          spec_flg_q, spec_flg_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         quotient_q, quotient_d;
    logic [3:0]          flags_q, flags_d;

    // ---------------- operand classification ----------------
    logic [4:0] a_exp, b_exp;
    logic [9:0] a_frac, b_frac;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_spec, in_sign;
    logic [15:0] dec_res;
    logic [3:0]  dec_flg;

    assign a_exp   = na[14:10];
    assign b_exp   = nb[14:10];
    assign a_frac  = na[9:0];
    assign b_frac  = nb[9:0];
    assign a_nan   = (&a_exp) && (|a_frac);
    assign b_nan   = (&b_exp) && (|b_frac);
    assign a_inf   = (&a_exp) && !(|a_frac);
    assign b_inf   = (&b_exp) && !(|b_frac);
    assign a_zero  = !(|a_exp) && !(|a_frac);
    assign b_zero  = !(|b_exp) && !(|b_frac);
    assign is_spec = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign in_sign = na[15] ^ nb[15];

    always_comb begin
        dec_res = {in_sign, 15'h0000};
        dec_flg = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            dec_res = 16'h7E00;
            dec_flg = 4'b1000;
        end else if (b_zero) begin
            dec_res = {in_sign, 5'h1F, 10'h000};
            dec_flg = 4'b0100;
        end else if (a_inf) begin
            dec_res = {in_sign, 5'h1F, 10'h000};
        end
        // remaining cases (finite/inf, 0/finite) keep the signed zero default
    end

    // ---------------- one restoring division step ----------------
    logic        rem_ge;
    logic [11:0] rem_sub;

    assign rem_ge  = rem_q >= {1'b0, mb_q};
    // rem_sub < mb after the step, so bit 11 is always clear and drops out of the shift
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    // ---------------- rounding and range check ----------------
    logic signed [6:0] e_raw, e_adj, e_fin;
    logic [9:0]        frac_pre;
    logic              guard, sticky, inc;
    logic [10:0]       frac_sum;
    logic [15:0]       rnd_res;
    logic [3:0]        rnd_flg;

    assign e_raw = ea_q - eb_q + BIAS_S;

    always_comb begin
        if (q_q[QBITS-1]) begin
            frac_pre = q_q[QBITS-2:2];
            guard    = q_q[1];
            sticky   = q_q[0] | (|rem_q);
            e_adj    = e_raw;
        end else begin
            frac_pre = q_q[QBITS-3:1];
            guard    = q_q[0];
            sticky   = |rem_q;
            e_adj    = e_raw - 7'sd1;
        end
    end

    // The hidden bit is always 1 here, so a carry out of the fraction means
    // the significand rolled over to 1.0: fraction becomes 0 and e bumps.
    assign inc      = guard && (sticky || frac_pre[0]);
    assign frac_sum = {1'b0, frac_pre} + {10'h000, inc};
    assign e_fin    = e_adj + {6'h00, frac_sum[10]};

    always_comb begin
        rnd_res = {sign_q, e_fin[4:0], frac_sum[9:0]};
        rnd_flg = 4'b0000;
        if (e_fin >= 7'sd31) begin
            rnd_res = {sign_q, 5'h1F, 10'h000};
            rnd_flg = 4'b0010;
        end else if (e_fin <= 7'sd0) begin
            rnd_res = {sign_q, 15'h0000};
            rnd_flg = 4'b0001;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        rem_d       = rem_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        spec_d      = spec_q;
        spec_res_d  = spec_res_q;
        spec_flg_d  = spec_flg_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        flags_d     = flags_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d     = in_sign;
                    spec_d     = is_spec;
                    spec_res_d = dec_res;
                    spec_flg_d = dec_flg;
                    ma_d       = {(|a_exp), a_frac};
                    mb_d       = {(|b_exp), b_frac};
                    ea_d       = (|a_exp) ? {2'b00, a_exp} : 7'sd1;
                    eb_d       = (|b_exp) ? {2'b00, b_exp} : 7'sd1;
                    // specials spend their single cycle in ROUND so the
                    // result registers are loaded from one place only
                    state_d    = is_spec ? S_ROUND : S_NORM;
                end
            end
            S_NORM: begin
                if (ma_q[10] && mb_q[10]) begin
                    rem_d   = {1'b0, ma_q};
                    q_d     = '0;
                    cnt_d   = 4'h0;
                    state_d = S_DIV;
                end else begin
                    if (!ma_q[10]) begin
                        ma_d = {ma_q[9:0], 1'b0};
                        ea_d = ea_q - 7'sd1;
                    end
                    if (!mb_q[10]) begin
                        mb_d = {mb_q[9:0], 1'b0};
                        eb_d = eb_q - 7'sd1;
                    end
                end
            end
            S_DIV: begin
                rem_d = {rem_sub[10:0], 1'b0};
                q_d   = {q_q[QBITS-2:0], rem_ge};
                cnt_d = cnt_q + 4'h1;
                if (cnt_q == LAST_Q) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                quotient_d  = spec_q ? spec_res_q : rnd_res;
                flags_d     = spec_q ? spec_flg_q : rnd_flg;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ma_q        <= 11'h000;
            mb_q        <= 11'h000;
            ea_q        <= 7'sd0;
            eb_q        <= 7'sd0;
            rem_q       <= 12'h000;
            q_q         <= '0;
            cnt_q       <= 4'h0;
            sign_q      <= 1'b0;
            spec_q      <= 1'b0;
            spec_res_q  <= 16'h0000;
            spec_flg_q  <= 4'b0000;
            out_valid_q <= 1'b0;
            quotient_q  <= 16'h0000;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
            spec_flg_q  <= spec_flg_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Purpose : self-checking bench for fp16_div_seq; directed vectors, scoreboard queue + monitor.
// Latency : measured in clock edges from the acceptance edge to the first out_valid cycle.
// Backpres: out_ready normally high; one case holds it low to check result stability.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] na = 16'h0000;
    logic [15:0] nb = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] quotient;
    logic [3:0]  flags;

    fp16_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .na        (na),
        .nb        (nb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // monitor: pops one expectation each time out_valid rises
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual quotient %0h required no result", quotient);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", int'(quotient), int'(mon_e.q));
                check("flags", int'(flags), int'(mon_e.f));
                check("latency", cyc - acc_cyc, mon_e.lat);
            end
        end
        prev_ov = out_valid;
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                         input logic [3:0] ef, input int el, input bit expect_out);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual 0 required 1");
        end
        na       = a;
        nb       = b;
        in_valid = 1'b1;
        if (expect_out) sb.push_back('{eq, ef, el});
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    localparam int NV = 16;
    logic [15:0] va [NV] = '{16'h3C00, 16'h4200, 16'h3C00, 16'h4200, 16'h3C00, 16'h0000, 16'h7C00, 16'h4000,
                             16'h7E00, 16'h3C00, 16'h7C00, 16'hBC00, 16'h7BFF, 16'h0400, 16'h0001, 16'h0200};
    logic [15:0] vb [NV] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3D00, 16'h0000, 16'h0000, 16'h4000, 16'hFC00,
                             16'h3C00, 16'h7C00, 16'hFC00, 16'h4000, 16'h1400, 16'h4000, 16'h0001, 16'h3C00};
    logic [15:0] vq [NV] = '{16'h3C00, 16'h3E00, 16'h3555, 16'h40CD, 16'h7C00, 16'h7E00, 16'h7C00, 16'h8000,
                             16'h7E00, 16'h0000, 16'h7E00, 16'hB800, 16'h7C00, 16'h0000, 16'h3C00, 16'h0000};
    logic [3:0]  vf [NV] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h0,
                             4'h8, 4'h0, 4'h8, 4'h0, 4'h2, 4'h1, 4'h0, 4'h1};
    int          vl [NV] = '{15, 15, 15, 15, 1, 1, 1, 1,
                             1, 1, 1, 15, 15, 15, 25, 16};

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        int ov_seen;

        // reset state
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_flags", int'(flags), 0);
        #21 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], vq[i], vf[i], vl[i], 1'b1);
        end
        drain();

        // backpressure: hold out_ready low for 5 cycles
        out_ready = 1'b0;
        issue(16'h3C00, 16'h3C00, 16'h3C00, 4'h0, 15, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached_valid", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_quotient", int'(quotient), 16'h3C00);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", int'(in_ready), 1);
        check("post_hs_out_valid", int'(out_valid), 0);

        // reset mid-division: no result may follow
        issue(16'h4200, 16'h4000, 16'h0000, 4'h0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_flags", int'(flags), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("abort_no_result", ov_seen, 0);

        // recovery after abort
        issue(16'h3C00, 16'h4200, 16'h3555, 4'h0, 15, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
